// File: rtl/fc_pkg.sv
// Shared constants and state encoding for the FC classifier frame controller,
// its accumulator and the bench.
package fc_pkg;

    localparam int INPUT_NUM = 3136;
    localparam int DATA_BITS = 8;
    localparam int ADDR_BITS = 12;
    localparam int SUM_BITS  = 32;
    localparam int FCNT_BITS = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        BIAS   = 3'd3,
        WAIT   = 3'd4,
        DECIDE = 3'd5
    } state_t;

endpackage

// File: rtl/fc_idx_cnt.sv
// Feature index counter: clears to zero, steps once per accepted feature and
// flags the terminal index INPUT_NUM-1 (wraps to zero so it never runs past it).
module fc_idx_cnt #(
    parameter int INPUT_NUM = fc_pkg::INPUT_NUM,
    parameter int ADDR_BITS = fc_pkg::ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 inc,
    output logic [ADDR_BITS-1:0] idx,
    output logic                 last
);

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(INPUT_NUM - 1);

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= last ? '0 : idx + ADDR_BITS'(1);
        end
    end

endmodule

// File: rtl/fc_frame_ctrl.sv
// Frame sequencer: streams INPUT_NUM features into the accumulator, adds bias, then
// compares the sum to T; result pulses INPUT_NUM+5 cycles after start at full input rate.
module fc_frame_ctrl #(
    parameter int                         INPUT_NUM  = fc_pkg::INPUT_NUM,
    parameter int                         DATA_BITS  = fc_pkg::DATA_BITS,
    parameter int                         ADDR_BITS  = fc_pkg::ADDR_BITS,
    parameter int                         SUM_BITS   = fc_pkg::SUM_BITS,
    parameter int                         ACC_LAT    = 1,
    parameter logic signed [SUM_BITS-1:0] T          = '0,
    parameter bit                         AUTO_REARM = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        in_valid,
    input  logic signed [DATA_BITS-1:0] in_data,
    output logic                        in_ready,
    output logic                        mac_clr,
    output logic                        mac_en,
    output logic signed [DATA_BITS-1:0] mac_data,
    output logic [ADDR_BITS-1:0]        w_addr,
    output logic                        bias_add,
    input  logic signed [SUM_BITS-1:0]  acc_sum,
    output logic                        sum_valid,
    output logic                        is_one,
    output logic                        busy,
    output logic [15:0]                 frame_cnt
);
    import fc_pkg::*;

    localparam int                WAIT_W    = (ACC_LAT > 1) ? $clog2(ACC_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACC_LAT - 1);

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 abort_hit;
    logic                 decide;
    logic                 idx_clr;
    logic                 idx_last;
    logic [ADDR_BITS-1:0] idx;
    logic [WAIT_W-1:0]    wait_cnt;

    assign in_ready  = (state == STREAM);
    assign busy      = (state != IDLE);
    assign abort_hit = abort & busy;
    // A feature offered on the abort cycle is dropped so it cannot race the clear.
    assign accept    = in_valid & in_ready & ~abort;
    assign decide    = (state == DECIDE) & ~abort;
    assign idx_clr   = (state == CLEAR) | abort_hit;

    fc_idx_cnt #(
        .INPUT_NUM (INPUT_NUM),
        .ADDR_BITS (ADDR_BITS)
    ) u_idx_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (accept),
        .idx  (idx),
        .last (idx_last)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = STREAM;
            STREAM:  if (accept && idx_last) state_nx = BIAS;
            BIAS:    state_nx = WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nx = DECIDE;
            DECIDE:  state_nx = AUTO_REARM ? CLEAR : IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mac_clr   <= 1'b0;
            mac_en    <= 1'b0;
            mac_data  <= '0;
            w_addr    <= '0;
            bias_add  <= 1'b0;
            sum_valid <= 1'b0;
            is_one    <= 1'b0;
            frame_cnt <= '0;
            wait_cnt  <= '0;
        end else begin
            // Registered so the clear lines up with the CLEAR state and follows an abort.
            mac_clr   <= (state_nx == CLEAR) | abort_hit;
            mac_en    <= accept;
            if (accept) begin
                mac_data <= in_data;
                w_addr   <= idx;
            end
            bias_add  <= (state == BIAS) & ~abort;
            sum_valid <= decide;
            if (decide) begin
                is_one    <= (acc_sum > T);
                frame_cnt <= frame_cnt + 16'd1;
            end
            wait_cnt  <= (state == WAIT) ? wait_cnt + WAIT_W'(1) : '0;
        end
    end

endmodule
